inst_line_fetcher: RTL and testbench
====================================

Name: inst_line_fetcher

Overview:
- Line refill engine directly downstream of the instruction cache.
- Accepts one 256-bit line request (addr/rd level handshake) from the cache.
- Issues sequential 32-bit word reads on the memory bus, assembles the line, and returns it with a one-cycle ack.
- Propagates the hardware page fault flag so the cache can leave the line invalid.

Parameters:
- LINE_BITS, 256, cache line width; must be a multiple of WORD_BITS.
- WORD_BITS, 32, memory bus data width.
- WORDS, LINE_BITS/WORD_BITS (8), words per line (derived localparam).
- OFF_BITS, GET_WIDTH(LINE_BITS/8-1) (5), byte offset bits within a line (derived localparam).

Ports:
- clk  in  1  sole clock; all state on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- line_addr_i  in  32  requested fetch address from cache; any byte address.
- line_rd_i  in  1  cache refill request, level; held until line_ack_o.
- line_data_o  out  256  assembled line; word k at bits [32k+31:32k].
- line_ack_o  out  1  one-cycle pulse; line_data_o and line_fault_o valid this cycle.
- line_fault_o  out  1  page fault for this line; meaningful only with line_ack_o.
- bus_addr_o  out  32  word-aligned bus read address.
- bus_rd_o  out  1  bus read strobe, level; held until bus_ack_i.
- bus_data_i  in  32  read data, sampled when bus_ack_i=1.
- bus_ack_i  in  1  bus completion, one cycle.
- bus_fault_i  in  1  translation fault, sampled with bus_ack_i.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; word counter 0; line buffer 0; fault flag 0.
  - Asserting reset mid-fetch drops bus_rd_o immediately, without waiting for a clock edge.
  - A bus_ack_i arriving after reset is ignored.
- State machine IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
- IDLE:
  - On line_rd_i=1, latch base = {line_addr_i[31:OFF_BITS], OFF_BITS'b0}.
  - Set cnt=0 (start slot per Optional Feature) and clear fault; go to REQ.
- REQ:
  - Drive bus_addr_o = base + 4*slot and bus_rd_o=1; go to WAIT.
- WAIT:
  - Hold bus_rd_o=1 and bus_addr_o stable until bus_ack_i.
  - On ack, write bus_data_i into slot and drop bus_rd_o.
  - If bus_fault_i=1, set fault and go to DONE; remaining words are not fetched, and their slots keep stale data.
  - Else if this was the WORDS-th word, go to DONE.
  - Else advance slot and go to REQ.
  - bus_rd_o is low for at least one cycle between words.
- DONE:
  - line_ack_o=1 for exactly one cycle; line_fault_o=fault; go to IDLE.
  - line_data_o holds its value until the next accepted request.
- Latency with a zero-wait bus (ack the cycle after bus_rd_o rises): 2*WORDS+1 cycles from the request edge to line_ack_o, i.e. 17 for defaults.
- The cache deasserts line_rd_i on the ack edge, so IDLE does not re-sample until the next cycle. No back-to-back acks are possible.
- line_rd_i dropping mid-fetch: ignored; the fetch completes and ack still pulses.
- line_addr_i changing mid-fetch: ignored, because base is latched.
- bus_ack_i outside WAIT: ignored.
- Slot arithmetic is modulo WORDS (GET_WIDTH(WORDS-1) bits). bus_addr_o never crosses the line boundary.

Optional Feature:
- Macro: INST_LINE_FETCHER_CRITICAL_WORD_FIRST_EN.
- Defined:
  - The first slot is line_addr_i[OFF_BITS-1:2], latched in IDLE.
  - Slots wrap modulo WORDS (e.g. 6,7,0,1,...,5); completion is still counted as WORDS words.
- Undefined:
  - The first slot is always 0 and slots run ascending 0..WORDS-1.
- Ack timing and the fault-abort rule are identical in both builds.

Decomposition:
- Shared header cache_defs.vh holds LINE_BITS, WORD_BITS and the state encodings (IDLE=0, REQ=1, WAIT=2, DONE=3). The cache and this fetcher both use it.
- GET_WIDTH comes from the existing functions.vh.
- No sub-module: the FSM, counter and line buffer are a single flat module.

Test Plan:
- Zero-wait bus returns word value 0x1000_0000+4k; request addr 0x0000_0164:
  - bus addresses are 0x160..0x17C ascending;
  - line_data_o[31:0]=0x1000_0000, [255:224]=0x1000_001C;
  - ack arrives 17 cycles after the request edge, with fault=0.
- Bus with 3 wait states per word: ack after 8*(1+4)+1=41 cycles; ack width is exactly 1; bus_rd_o is low for exactly 1 cycle between words.
- bus_fault_i=1 on the 3rd word of a fetch at 0x2000:
  - exactly 3 bus reads occur (0x2000, 0x2004, 0x2008);
  - ack with line_fault_o=1 on the next cycle;
  - no further bus_rd_o.
- rst_n pulsed low during WAIT of word 4:
  - bus_rd_o and all outputs drop to 0 asynchronously;
  - after release with line_rd_i=1, a fresh fetch restarts at word 0.
- line_rd_i deasserted and line_addr_i changed mid-fetch: addresses stay on the original line, and ack still pulses once.
- With CRITICAL_WORD_FIRST_EN defined, request 0x0000_0198: the address order is 0x198, 0x19C, 0x180, ..., 0x194, and each word lands in its correct bit slot.

Source files
------------

// File: rtl/inst_line_fetcher_pkg.sv
// Shared definitions for the instruction-line refill engine: default line
// and word widths, the fetch FSM state encoding and a width helper.
package inst_line_fetcher_pkg;

  // Default geometry shared with the instruction cache.
  localparam int LINE_BITS_DEF = 256;
  localparam int WORD_BITS_DEF = 32;

  // Number of bits needed to represent 'value' (minimum 1).
  function automatic int get_width(input int value);
    for (int w = 1; w < 32; w++) begin
      if ((value >> w) == 0) begin
        return w;
      end
    end
    return 32;
  endfunction

  // Fetch FSM encoding shared with the cache: IDLE=0, REQ=1, WAIT=2, DONE=3.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_line_fetcher.sv
// Instruction-line refill engine. Accepts one line request from the cache,
// reads the line word by word over the memory bus, assembles it and returns
// it with a single-cycle ack. A bus translation fault aborts the remaining
// reads and is reported with the ack.
//
// Optional build macro: INST_LINE_FETCHER_CRITICAL_WORD_FIRST_EN
//   defined   - reads start at the word holding the requested address and
//               wrap around the line.
//   undefined - reads always run from word 0 upwards.
//
// Handshakes:
//   line_rd_i is a level request held by the cache until line_ack_o; the ack
//   is a one-cycle pulse and line_data_o/line_fault_o are valid with it.
//   bus_rd_o is a level strobe held with a stable bus_addr_o until the bus
//   answers with a one-cycle bus_ack_i; bus_data_i/bus_fault_i are sampled on
//   that cycle only, and bus_ack_i outside an outstanding read is ignored.
module inst_line_fetcher
  import inst_line_fetcher_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          line_addr_i,
  input  logic                 line_rd_i,
  output logic [LINE_BITS-1:0] line_data_o,
  output logic                 line_ack_o,
  output logic                 line_fault_o,
  output logic [31:0]          bus_addr_o,
  output logic                 bus_rd_o,
  input  logic [WORD_BITS-1:0] bus_data_i,
  input  logic                 bus_ack_i,
  input  logic                 bus_fault_i
);

  localparam int WORDS     = LINE_BITS / WORD_BITS;
  localparam int OFF_BITS  = get_width(LINE_BITS / 8 - 1);
  localparam int WB_BITS   = get_width(WORD_BITS / 8 - 1);
  localparam int SLOT_BITS = get_width(WORDS - 1);

  localparam logic [SLOT_BITS-1:0] LAST_CNT = SLOT_BITS'(WORDS - 1);

  fetch_state_e state_q, state_d;

  logic [31-OFF_BITS:0]  line_tag_q;
  logic [SLOT_BITS-1:0]  slot_q;
  logic [SLOT_BITS-1:0]  cnt_q;
  logic                  fault_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [31:0]           bus_addr_q;
  logic                  bus_rd_q;

  logic                  accept;
  logic                  issue;
  logic                  capture;
  logic                  last_word;
  logic [SLOT_BITS-1:0]  first_slot;

  // Byte-within-word bits are never needed; the word index bits are only
  // used by the critical-word-first build.
  logic [OFF_BITS-1:0]   addr_lsb_unused;
  assign addr_lsb_unused = line_addr_i[OFF_BITS-1:0];

`ifdef INST_LINE_FETCHER_CRITICAL_WORD_FIRST_EN
  assign first_slot = line_addr_i[OFF_BITS-1:WB_BITS];
`else
  assign first_slot = '0;
`endif

  assign last_word = (cnt_q == LAST_CNT);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (line_rd_i) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        issue   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_ack_i) begin
          capture = 1'b1;
          if (bus_fault_i || last_word) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request latch, slot/word counters and fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_tag_q <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
    end else if (accept) begin
      line_tag_q <= line_addr_i[31:OFF_BITS];
      slot_q     <= first_slot;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
    end else if (capture) begin
      // Slot wraps modulo WORDS, so the read address stays inside the line.
      slot_q  <= slot_q + 1'b1;
      cnt_q   <= cnt_q + 1'b1;
      fault_q <= bus_fault_i;
    end
  end

  // Bus strobe and address: raised on REQ, dropped on the ack edge so the
  // strobe is low for the whole REQ cycle before the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rd_q   <= 1'b0;
      bus_addr_q <= '0;
    end else if (issue) begin
      bus_rd_q   <= 1'b1;
      bus_addr_q <= {line_tag_q, slot_q, {WB_BITS{1'b0}}};
    end else if (capture) begin
      bus_rd_q   <= 1'b0;
    end
  end

  // Line buffer: each returned word lands in its own slot; slots not read
  // (after a fault) keep whatever they held before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (capture) begin
      line_q[slot_q*WORD_BITS +: WORD_BITS] <= bus_data_i;
    end
  end

  assign line_data_o  = line_q;
  assign line_ack_o   = (state_q == ST_DONE);
  assign line_fault_o = (state_q == ST_DONE) & fault_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_rd_o     = bus_rd_q;

endmodule

// File: tb/tb_inst_line_fetcher.sv
// Directed bench for inst_line_fetcher: a table of line fetches with
// hand-computed latency/read-count/fault expectations, plus sequences for
// async reset mid-fetch, request withdrawal mid-fetch and stray bus acks.
module tb_inst_line_fetcher;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]  line_addr_i;
  logic         line_rd_i;
  logic [255:0] line_data_o;
  logic         line_ack_o;
  logic         line_fault_o;
  logic [31:0]  bus_addr_o;
  logic         bus_rd_o;
  logic [31:0]  bus_data_i;
  logic         bus_ack_i;
  logic         bus_fault_i;

  inst_line_fetcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_addr_i  (line_addr_i),
    .line_rd_i    (line_rd_i),
    .line_data_o  (line_data_o),
    .line_ack_o   (line_ack_o),
    .line_fault_o (line_fault_o),
    .bus_addr_o   (bus_addr_o),
    .bus_rd_o     (bus_rd_o),
    .bus_data_i   (bus_data_i),
    .bus_ack_i    (bus_ack_i),
    .bus_fault_i  (bus_fault_i)
  );

  // ---------------- bus responder ----------------
  int          bus_waits;
  int          fault_word;
  logic [31:0] data_base;
  int          wcnt;
  int          nreads;
  int          low_cnt;
  logic        prev_rd;
  bit          force_ack;
  logic [31:0] addr_log[$];
  int          gap_q[$];

  // Inputs change on negedge; ack returns after bus_waits high cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_ack_i   = 1'b0;
      bus_fault_i = 1'b0;
      wcnt        = 0;
      prev_rd     = 1'b0;
      low_cnt     = 0;
    end else begin
      if (bus_rd_o && !prev_rd && nreads > 0) gap_q.push_back(low_cnt);
      if (bus_rd_o) low_cnt = 0; else low_cnt++;
      prev_rd     = bus_rd_o;
      bus_ack_i   = 1'b0;
      bus_fault_i = 1'b0;
      if (force_ack) begin
        bus_ack_i   = 1'b1;
        bus_fault_i = 1'b1;
        bus_data_i  = 32'hDEAD_BEEF;
      end else if (bus_rd_o) begin
        if (wcnt == bus_waits) begin
          wcnt        = 0;
          nreads++;
          bus_ack_i   = 1'b1;
          bus_data_i  = data_base + {27'd0, bus_addr_o[4:0]};
          bus_fault_i = (nreads == fault_word);
          addr_log.push_back(bus_addr_o);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_line[8];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_vec();
    logic [255:0] v;
    for (int s = 0; s < 8; s++) v[s*32 +: 32] = exp_line[s];
    return v;
  endfunction

  function automatic int first_slot_of(input logic [31:0] a);
`ifdef INST_LINE_FETCHER_CRITICAL_WORD_FIRST_EN
    return int'(a[4:2]);
`else
    return 0;
`endif
  endfunction

  // Expected address order and line contents for 'n' words read from 'a'.
  task automatic model_fetch(input logic [31:0] a, input int n, input logic [31:0] dbase);
    int slot;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      slot = (first_slot_of(a) + k) % 8;
      exp_q.push_back({a[31:5], 5'd0} + 32'(4 * slot));
      exp_line[slot] = dbase + 32'(4 * slot);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic arm_bus(input int waits, input int fword, input logic [31:0] dbase);
    bus_waits  = waits;
    fault_word = fword;
    data_base  = dbase;
    nreads     = 0;
    addr_log.delete();
    gap_q.delete();
  endtask

  // Runs one request; lat counts clock edges from the request edge to the
  // edge at which the cache sees the ack.
  task automatic do_fetch(input logic [31:0] addr, output int lat, output bit seen,
                          output bit flt, output int acks);
    @(negedge clk);
    line_addr_i = addr;
    line_rd_i   = 1'b1;
    @(posedge clk);
    lat = 0; seen = 0; flt = 0; acks = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (line_ack_o) begin
        seen = 1; lat = i + 1; flt = line_fault_o; acks++;
        line_rd_i = 1'b0;
      end
    end
    line_rd_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (line_ack_o) acks++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    int          waits;
    int          fault_word;
    logic [31:0] dbase;
    int          exp_lat;
    int          exp_reads;
    bit          exp_fault;
  } vec_t;

  vec_t vt[6];
  int   lat, acks;
  bit   seen, flt;
  bit   found;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h0000_0164, 0, 0, 32'h1000_0000, 17, 8, 1'b0};
    vt[1] = '{32'h0000_0A08, 3, 0, 32'h2000_0000, 41, 8, 1'b0};
    vt[2] = '{32'h0000_2000, 0, 3, 32'h3000_0000,  7, 3, 1'b1};
    vt[3] = '{32'h0000_0198, 1, 0, 32'h4000_0000, 25, 8, 1'b0};
    vt[4] = '{32'h0000_7FE0, 0, 1, 32'h5000_0000,  3, 1, 1'b1};
    vt[5] = '{32'hFFFF_FFFC, 2, 8, 32'h6000_0000, 33, 8, 1'b1};

    rst_n = 1'b0; line_addr_i = '0; line_rd_i = 1'b0; force_ack = 1'b0;
    bus_data_i = '0; bus_ack_i = 1'b0; bus_fault_i = 1'b0;
    arm_bus(0, 0, 32'h0);
    for (int s = 0; s < 8; s++) exp_line[s] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_line_data", line_data_o, '0);
    check("reset_ack",       line_ack_o, 0);
    check("reset_fault",     line_fault_o, 0);
    check("reset_bus_rd",    bus_rd_o, 0);
    check("reset_bus_addr",  bus_addr_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven fetches.
    foreach (vt[i]) begin
      arm_bus(vt[i].waits, vt[i].fault_word, vt[i].dbase);
      model_fetch(vt[i].addr, vt[i].exp_reads, vt[i].dbase);
      do_fetch(vt[i].addr, lat, seen, flt, acks);
      check($sformatf("v%0d_ack_seen", i), seen, 1);
      check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("v%0d_ack_width", i), acks, 1);
      check($sformatf("v%0d_fault", i), flt, vt[i].exp_fault);
      check($sformatf("v%0d_nreads", i), nreads, vt[i].exp_reads);
      check($sformatf("v%0d_log_len", i), addr_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < addr_log.size(); k++)
        check($sformatf("v%0d_addr%0d", i, k), addr_log[k], exp_q[k]);
      foreach (gap_q[g]) check($sformatf("v%0d_gap%0d", i, g), gap_q[g], 1);
      check($sformatf("v%0d_line", i), line_data_o, exp_vec());
      check($sformatf("v%0d_idle_rd", i), bus_rd_o, 0);
      check($sformatf("v%0d_idle_fault", i), line_fault_o, 0);
    end

    // Explicit word-position checks for the 0x164 request (default order).
    arm_bus(0, 0, 32'h1000_0000);
    model_fetch(32'h0000_0164, 8, 32'h1000_0000);
    do_fetch(32'h0000_0164, lat, seen, flt, acks);
    check("w0_slot", line_data_o[31:0], 32'h1000_0000);
    check("w7_slot", line_data_o[255:224], 32'h1000_001C);

    // Stray bus ack while idle must not touch the line buffer or start a read.
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ack_line", line_data_o, exp_vec());
    check("stray_ack_ack", line_ack_o, 0);
    check("stray_ack_rd", bus_rd_o, 0);

    // Async reset during the wait of word 4, then a fresh fetch from word 0.
    arm_bus(2, 0, 32'h7000_0000);
    @(negedge clk);
    line_addr_i = 32'h0000_0300;
    line_rd_i   = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (nreads == 3 && bus_rd_o && !bus_ack_i) found = 1;
    end
    check("rst_reach_word4", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_bus_rd", bus_rd_o, 0);
    check("rst_async_bus_addr", bus_addr_o, 0);
    check("rst_async_ack", line_ack_o, 0);
    check("rst_async_fault", line_fault_o, 0);
    check("rst_async_line", line_data_o, '0);
    for (int s = 0; s < 8; s++) exp_line[s] = '0;
    nreads = 0;
    addr_log.delete();
    gap_q.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_fetch(32'h0000_0300, 8, 32'h7000_0000);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (line_ack_o) begin seen = 1; line_rd_i = 1'b0; end
    end
    line_rd_i = 1'b0;
    check("rst_refetch_ack", seen, 1);
    check("rst_refetch_nreads", nreads, 8);
    check("rst_refetch_first", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'h0000_0300);
    check("rst_refetch_line", line_data_o, exp_vec());
    repeat (4) @(negedge clk);

    // Request dropped and address changed mid-fetch: fetch finishes on the
    // original line and acks once, with no follow-up fetch.
    arm_bus(0, 0, 32'h8000_0000);
    model_fetch(32'h0000_0440, 8, 32'h8000_0000);
    @(negedge clk);
    line_addr_i = 32'h0000_0440;
    line_rd_i   = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (nreads == 4) found = 1;
    end
    check("drop_reach_word4", found, 1);
    line_rd_i   = 1'b0;
    line_addr_i = 32'h0000_8040;
    acks = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (line_ack_o) acks++;
    end
    check("drop_ack_count", acks, 1);
    check("drop_nreads", nreads, 8);
    for (int k = 0; k < addr_log.size(); k++)
      check($sformatf("drop_addr%0d", k), addr_log[k], exp_q[k]);
    check("drop_line", line_data_o, exp_vec());
    check("drop_idle_rd", bus_rd_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
